// File: rtl/lcd_char_responder_if.sv
// Host-side HD44780 parallel bus between an LCD controller (master) and the
// character responder model (slave).
interface lcd_char_responder_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_data_in;
    logic [7:0] LCD_data_out;
    logic       LCD_data_oe;

    modport master (
        output LCD_E, LCD_RS, LCD_RW, LCD_data_in,
        input  LCD_data_out, LCD_data_oe
    );

    modport slave (
        input  LCD_E, LCD_RS, LCD_RW, LCD_data_in,
        output LCD_data_out, LCD_data_oe
    );
endinterface

// File: rtl/lcd_char_responder.sv
// HD44780-style character LCD responder: 80-byte DDRAM, address counter, busy timing.
// Optional macro LCD_RESP_BUSY_CHECK_EN: accesses made while busy are ignored and flagged on proto_err.
module lcd_char_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1600
) (
    input  logic                clk,
    input  logic                reset,
    lcd_char_responder_if.slave bus,
    output logic                busy,
    input  logic [6:0]          dbg_addr,
    output logic [7:0]          dbg_rdata,
    output logic                proto_err
);

    localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {IDLE, CLEAR, BUSY} state_t;

    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Lines live at 0x00-0x27 and 0x40-0x67; pack them into 0..79.
    function automatic logic [6:0] addr_idx(input logic [6:0] a);
        return (a < 7'h28) ? a : (a - 7'h18);
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h40)      return 7'h27;
            else if (a == 7'h00) return 7'h67;
            else                 return a - 7'd1;
        end
    endfunction

    logic [7:0]    mem [0:79];
    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic [6:0]    clr_idx;
    logic [6:0]    ac;
    logic          id;
    logic          e_meta, e_s, e_s_p1;
    logic          rs_l, rw_l;
    logic [7:0]    data_l;
    logic          commit, allow, wr_go, rd_go, in_go, mem_we, clr_we;
    logic          ac_valid, is_clear, is_home, is_entry, is_setac;
    logic [7:0]    rd_data;

    // E synchronizer and access capture; commit fires on the falling edge of e_s
    always_ff @(posedge clk) begin
        if (reset) begin
            e_meta <= 1'b0;
            e_s    <= 1'b0;
            e_s_p1 <= 1'b0;
            rs_l   <= 1'b0;
            rw_l   <= 1'b0;
        end else begin
            e_meta <= bus.LCD_E;
            e_s    <= e_meta;
            e_s_p1 <= e_s;
            if (e_s) begin
                rs_l <= bus.LCD_RS;
                rw_l <= bus.LCD_RW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (e_s) data_l <= bus.LCD_data_in;
    end

    assign commit   = e_s_p1 & ~e_s;
    assign ac_valid = addr_valid(ac);
    assign is_clear = (data_l == 8'h01);
    assign is_home  = (data_l[7:1] == 7'h01);
    assign is_entry = (data_l[7:2] == 6'h01);
    assign is_setac = data_l[7];

`ifdef LCD_RESP_BUSY_CHECK_EN
    logic busy_now, proto_err_q;
    // The expiry cycle of the busy counter already counts as idle.
    assign busy_now = (state_q == CLEAR) || ((state_q == BUSY) && (cnt != '0));
    assign allow    = ~busy_now;

    always_ff @(posedge clk) begin
        if (reset)
            proto_err_q <= 1'b0;
        else if (commit && !(!rs_l && rw_l) && busy_now)
            proto_err_q <= 1'b1;
    end
    assign proto_err = proto_err_q;
`else
    assign allow     = 1'b1;
    assign proto_err = 1'b0;
`endif

    assign wr_go  = commit & rs_l & ~rw_l & allow & (state_q != CLEAR);
    assign rd_go  = commit & rs_l & rw_l & allow;
    assign in_go  = commit & ~rs_l & ~rw_l & allow;
    assign mem_we = wr_go & ac_valid;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_go && is_clear)  state_d = CLEAR;
                else if (in_go || wr_go) state_d = BUSY;
            end
            CLEAR: begin
                if (in_go && is_clear)      state_d = CLEAR;
                else if (clr_idx == 7'd79)  state_d = (cnt == '0) ? IDLE : BUSY;
            end
            BUSY: begin
                if (in_go && is_clear)       state_d = CLEAR;
                else if (in_go || wr_go)     state_d = BUSY;
                else if (cnt == '0)          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        clr_we = (state_q == CLEAR) && !reset;
    end

    // The busy counter runs straight through CLEAR into BUSY without reloading
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            clr_idx <= '0;
        end else if (in_go && is_clear) begin
            cnt     <= CLEAR_LOAD;
            clr_idx <= '0;
        end else if (state_q == CLEAR) begin
            clr_idx <= clr_idx + 7'd1;
            if (cnt != '0) cnt <= cnt - CNT_ONE;
        end else if (in_go) begin
            cnt <= is_home ? CLEAR_LOAD : BUSY_LOAD;
        end else if (wr_go) begin
            cnt <= BUSY_LOAD;
        end else if ((state_q == BUSY) && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ac <= 7'h00;
            id <= 1'b1;
        end else if (in_go) begin
            if (is_clear) begin
                ac <= 7'h00;
                id <= 1'b1;
            end else if (is_home) begin
                ac <= 7'h00;
            end else if (is_entry) begin
                id <= data_l[1];
            end else if (is_setac) begin
                ac <= data_l[6:0];
            end
        end else if ((wr_go || rd_go) && ac_valid) begin
            ac <= ac_step(ac, id);
        end
    end

    // DDRAM keeps its contents across reset; only a clear instruction initialises it
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_idx] <= 8'h20;
        else if (mem_we && !reset)
            mem[addr_idx(ac)] <= data_l;
    end

    always_ff @(posedge clk) begin
        if (reset)
            dbg_rdata <= 8'h00;
        else
            dbg_rdata <= addr_valid(dbg_addr) ? mem[addr_idx(dbg_addr)] : 8'h20;
    end

    assign rd_data          = bus.LCD_RS ? (ac_valid ? mem[addr_idx(ac)] : 8'h20) : {busy, ac};
    assign bus.LCD_data_oe  = e_s & bus.LCD_RW;
    assign bus.LCD_data_out = bus.LCD_data_oe ? rd_data : 8'h00;

endmodule
